// File: rtl/dvi_pixel_prep.sv
// rtl/dvi_pixel_prep.sv - 6-to-8-bit colour expansion with raster lock qualification for the DVI encoder
module dvi_pixel_prep #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int WDOG_BITS       = 21
) (
    input  logic        clk_dot4x,
    input  logic        rst_n,
    input  logic [5:0]  in_red,
    input  logic [5:0]  in_green,
    input  logic [5:0]  in_blue,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_active,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de,
    output logic        locked,
    output logic [9:0]  lines_per_frame
);

    localparam logic [WDOG_BITS-1:0] WDOG_MAX = '1;
    localparam logic [9:0]           LINE_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    // v*255 computed as v*256 - v, which never underflows for 6-bit v
    function automatic logic [13:0] times_255(input logic [5:0] v);
        return {v, 8'd0} - {8'd0, v};
    endfunction

    function automatic logic [7:0] div_63(input logic [13:0] p);
        logic [13:0] q;
        q = p / 14'd63;
        return q[7:0];
    endfunction

    logic [13:0]          red_s1;
    logic [13:0]          green_s1;
    logic [13:0]          blue_s1;
    logic                 hsync_s1;
    logic                 vsync_s1;
    logic                 de_s1;
    logic [7:0]           red_s2;
    logic [7:0]           green_s2;
    logic [7:0]           blue_s2;
    logic                 hsync_s2;
    logic                 vsync_s2;
    logic                 de_s2;

    state_t               state;
    logic [9:0]           line_cnt;
    logic [WDOG_BITS-1:0] wdog;
    logic                 hs_prev;
    logic                 vs_prev;
    logic                 hs_asserted;
    logic                 vs_asserted;
    logic                 hs_lead;
    logic                 vs_lead;
    logic                 pixel_on;

    assign hs_asserted = in_hsync ^ SYNC_ACTIVE_LOW;
    assign vs_asserted = in_vsync ^ SYNC_ACTIVE_LOW;
    assign hs_lead     = hs_asserted & ~hs_prev;
    assign vs_lead     = vs_asserted & ~vs_prev;

    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            red_s1   <= '0;
            green_s1 <= '0;
            blue_s1  <= '0;
            hsync_s1 <= SYNC_ACTIVE_LOW;
            vsync_s1 <= SYNC_ACTIVE_LOW;
            de_s1    <= 1'b0;
            red_s2   <= '0;
            green_s2 <= '0;
            blue_s2  <= '0;
            hsync_s2 <= SYNC_ACTIVE_LOW;
            vsync_s2 <= SYNC_ACTIVE_LOW;
            de_s2    <= 1'b0;
        end else begin
            red_s1   <= times_255(in_red);
            green_s1 <= times_255(in_green);
            blue_s1  <= times_255(in_blue);
            hsync_s1 <= in_hsync;
            vsync_s1 <= in_vsync;
            de_s1    <= in_active;
            red_s2   <= div_63(red_s1);
            green_s2 <= div_63(green_s1);
            blue_s2  <= div_63(blue_s1);
            hsync_s2 <= hsync_s1;
            vsync_s2 <= vsync_s1;
            de_s2    <= de_s1;
        end
    end

    // Raster qualifier: all decisions are taken on a vsync leading edge,
    // except the watchdog which drops back to SEARCH on its own.
    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            state           <= ST_SEARCH;
            locked          <= 1'b0;
            lines_per_frame <= '0;
            line_cnt        <= '0;
            wdog            <= '0;
            hs_prev         <= 1'b0;
            vs_prev         <= 1'b0;
        end else begin
            hs_prev <= hs_asserted;
            vs_prev <= vs_asserted;
            if (vs_lead) begin
                line_cnt <= hs_lead ? 10'd1 : 10'd0;
                wdog     <= '0;
                case (state)
                    ST_SEARCH: begin
                        state  <= ST_MEASURE;
                        locked <= 1'b0;
                    end
                    ST_MEASURE: begin
                        state           <= ST_VERIFY;
                        lines_per_frame <= line_cnt;
                        locked          <= 1'b0;
                    end
                    ST_VERIFY: begin
                        if (line_cnt == lines_per_frame) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            lines_per_frame <= line_cnt;
                        end
                    end
                    ST_LOCKED: begin
                        if (line_cnt != lines_per_frame) begin
                            state           <= ST_VERIFY;
                            locked          <= 1'b0;
                            lines_per_frame <= line_cnt;
                        end
                    end
                    default: begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end else begin
                if (hs_lead && line_cnt != LINE_MAX) begin
                    line_cnt <= line_cnt + 10'd1;
                end
                if (wdog == WDOG_MAX) begin
                    state  <= ST_SEARCH;
                    locked <= 1'b0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

    // Gate with the current lock so the first qualified pixel is whole
    assign pixel_on  = de_s2 & locked;
    assign out_de    = pixel_on;
    assign out_red   = pixel_on ? red_s2   : 8'd0;
    assign out_green = pixel_on ? green_s2 : 8'd0;
    assign out_blue  = pixel_on ? blue_s2  : 8'd0;
    assign out_hsync = hsync_s2;
    assign out_vsync = vsync_s2;

endmodule

// File: tb/tb_dvi_pixel_prep.sv
// tb/tb_dvi_pixel_prep.sv - self-checking bench for dvi_pixel_prep
module tb_dvi_pixel_prep;

    localparam int WDOG_BITS = 12;
    localparam int WD_MAX    = (1 << WDOG_BITS) - 1;
    localparam int LINE_LEN  = 8;

    logic       clk_dot4x = 1'b0;
    logic       rst_n;
    logic [5:0] in_red, in_green, in_blue;
    logic       in_hsync, in_vsync, in_active;
    logic [7:0] out_red, out_green, out_blue;
    logic       out_hsync, out_vsync, out_de, locked;
    logic [9:0] lines_per_frame;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    dvi_pixel_prep #(.SYNC_ACTIVE_LOW(1'b1), .WDOG_BITS(WDOG_BITS)) dut (
        .clk_dot4x      (clk_dot4x),
        .rst_n          (rst_n),
        .in_red         (in_red),
        .in_green       (in_green),
        .in_blue        (in_blue),
        .in_hsync       (in_hsync),
        .in_vsync       (in_vsync),
        .in_active      (in_active),
        .out_red        (out_red),
        .out_green      (out_green),
        .out_blue       (out_blue),
        .out_hsync      (out_hsync),
        .out_vsync      (out_vsync),
        .out_de         (out_de),
        .locked         (locked),
        .lines_per_frame(lines_per_frame)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    function automatic int ref_scale(input int v);
        return (v * 255) / 63;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is qualified once the last two complete
    // frame counts since the raster was (re)acquired agree.
    bit   m_started;
    int   m_frames[$];
    int   m_lines, m_wd, m_lpf;
    bit   m_hs_prev, m_vs_prev, m_locked;
    int   m_r[2], m_g[2], m_b[2];
    bit   m_hs[2], m_vs[2], m_de[2];

    always @(posedge clk_dot4x) begin
        bit hs_a, vs_a, hl, vl;
        if (!rst_n) begin
            m_started = 0; m_frames.delete(); m_lines = 0; m_wd = 0; m_lpf = 0;
            m_hs_prev = 0; m_vs_prev = 0; m_locked = 0;
            for (int i = 0; i < 2; i++) begin
                m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_hs[i] = 1; m_vs[i] = 1; m_de[i] = 0;
            end
        end else begin
            hs_a = !in_hsync;
            vs_a = !in_vsync;
            hl = hs_a && !m_hs_prev;
            vl = vs_a && !m_vs_prev;
            if (vl) begin
                if (m_started) begin
                    m_frames.push_back(m_lines);
                    m_lpf = m_lines;
                end
                m_started = 1;
                m_lines = hl ? 1 : 0;
                m_wd = 0;
            end else begin
                if (hl && m_lines < 1023) m_lines++;
                if (m_wd == WD_MAX) begin
                    m_started = 0;
                    m_frames.delete();
                end else begin
                    m_wd++;
                end
            end
            m_locked = m_started && m_frames.size() >= 2 &&
                       m_frames[m_frames.size()-1] == m_frames[m_frames.size()-2];
            m_hs_prev = hs_a;
            m_vs_prev = vs_a;
            m_r[1] = m_r[0]; m_g[1] = m_g[0]; m_b[1] = m_b[0];
            m_hs[1] = m_hs[0]; m_vs[1] = m_vs[0]; m_de[1] = m_de[0];
            m_r[0] = in_red; m_g[0] = in_green; m_b[0] = in_blue;
            m_hs[0] = in_hsync; m_vs[0] = in_vsync; m_de[0] = in_active;
        end
    end

    always @(negedge clk_dot4x) begin
        logic [37:0] act, exp;
        bit on;
        if (chk_en) begin
            on  = m_de[1] && m_locked;
            exp = {8'(on ? ref_scale(m_r[1]) : 0), 8'(on ? ref_scale(m_g[1]) : 0),
                   8'(on ? ref_scale(m_b[1]) : 0), m_hs[1], m_vs[1], on, m_locked, 10'(m_lpf)};
            act = {out_red, out_green, out_blue, out_hsync, out_vsync, out_de, locked, lines_per_frame};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic pixel(input int r, input int g, input int b, input bit hs, input bit vs, input bit act);
        in_red = 6'(r); in_green = 6'(g); in_blue = 6'(b);
        in_hsync = !hs; in_vsync = !vs; in_active = act;
        @(posedge clk_dot4x);
        #1;
    endtask

    logic       snap_locked;
    logic [9:0] snap_lpf;

    task automatic line(input bit vs, input bit first);
        for (int c = 0; c < LINE_LEN; c++) begin
            pixel($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                  c < 2, vs, !vs && c >= 2);
            if (first && c == 0) begin
                snap_locked = locked;
                snap_lpf    = lines_per_frame;
            end
        end
    endtask

    task automatic frame(input int n);
        for (int l = 0; l < n; l++) line(l < 3, l == 0);
    endtask

    typedef struct {
        int r, g, b;
        int er, eg, eb;
    } vec_t;
    vec_t vecs[$];

    initial begin
        vec_t v;
        int   consts[6][2] = '{'{0, 0}, '{1, 4}, '{16, 64}, '{32, 129}, '{62, 250}, '{63, 255}};
        bit   lost;

        for (int i = 0; i < 6; i++) begin
            v.r = consts[i][0]; v.er = consts[i][1];
            v.g = consts[5-i][0]; v.eg = consts[5-i][1];
            v.b = consts[(i+2)%6][0]; v.eb = consts[(i+2)%6][1];
            vecs.push_back(v);
        end
        for (int i = 0; i < 64; i++) begin
            v.r = i; v.g = 63 - i; v.b = (i * 5) % 64;
            v.er = ref_scale(v.r); v.eg = ref_scale(v.g); v.eb = ref_scale(v.b);
            vecs.push_back(v);
        end

        rst_n = 1'b0;
        in_red = 6'd63; in_green = 6'd63; in_blue = 6'd63;
        in_hsync = 1'b1; in_vsync = 1'b1; in_active = 1'b1;
        repeat (3) @(posedge clk_dot4x);
        #1;
        check("rst_red", out_red, 0);
        check("rst_de", out_de, 0);
        check("rst_hsync", out_hsync, 1);
        check("rst_vsync", out_vsync, 1);
        check("rst_locked", locked, 0);
        check("rst_lpf", lines_per_frame, 0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (5) pixel(63, 63, 63, 0, 0, 1);
        check("unlocked_red", out_red, 0);

        frame(312);
        frame(312);
        check("pal_lpf_after_f1", snap_lpf, 312);
        check("pal_unlocked_at_f2", snap_locked, 0);
        check("pal_unlocked_before_f3", locked, 0);
        frame(312);
        check("pal_lock_at_f3", snap_locked, 1);

        for (int j = 0; j <= vecs.size(); j++) begin
            if (j < vecs.size()) pixel(vecs[j].r, vecs[j].g, vecs[j].b, 0, 0, 1);
            else pixel(0, 0, 0, 0, 0, 0);
            if (j >= 1) begin
                check("vec_red", out_red, vecs[j-1].er);
                check("vec_green", out_green, vecs[j-1].eg);
                check("vec_blue", out_blue, vecs[j-1].eb);
            end
        end

        frame(263);
        check("ntsc_still_locked", snap_locked, 1);
        frame(263);
        check("ntsc_drop", snap_locked, 0);
        check("ntsc_lpf_capture", snap_lpf, 263);
        frame(263);
        check("ntsc_relock", snap_locked, 1);
        check("ntsc_lpf", lines_per_frame, 263);

        lost = 1'b0;
        for (int l = 0; l < 700 && !lost; l++) begin
            line(0, 0);
            lost = !locked;
        end
        check("wdog_drop", lost, 1);
        check("wdog_lpf_kept", lines_per_frame, 263);
        repeat (3) line(0, 0);
        check("wdog_red_blank", out_red, 0);

        frame(312);
        frame(312);
        frame(312);
        check("relock_after_wdog", snap_locked, 1);
        repeat (150) line(0, 0);
        rst_n = 1'b0;
        pixel(10, 20, 30, 0, 0, 1);
        check("midrst_locked", locked, 0);
        check("midrst_lpf", lines_per_frame, 0);
        rst_n = 1'b1;
        frame(312);
        check("midrst_no_history", snap_locked, 0);
        repeat (20) line(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
